// File: rtl/uart_tx_ser.sv
`timescale 1ns/1ps
// uart_tx_ser: UART transmit serializer draining a fifo_buf read port.
// Pops one word whenever idle and the FIFO has data, then drives a frame of
// start bit, DATA_W data bits LSB-first, optional parity and STOP_BITS stop bits.
// The bit period is (baud_div_i + 1) clocks, latched at each pop.
//
// Ports:
//   clk_i       system clock
//   rst_n_i     asynchronous reset, active low
//   baud_div_i  bit period minus one, in clk_i cycles
//   data_i      word from FIFO rd_data_o
//   rdy_i       FIFO rd_rdy_o, data_i valid while high
//   rd_o        pop strobe to FIFO rd_i (combinational, IDLE only)
//   tx_o        serial line, idle high, registered
//   busy_o      frame in progress, registered
module uart_tx_ser #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DIV_W-1:0]  baud_div_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rdy_i,
    output logic              rd_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    baud_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic                parity_q;
    logic                tx_q;
    logic                busy_q;

    logic                baud_done_d;
    logic                parity_d;

    // End of the current bit period.
    assign baud_done_d = (baud_cnt_q == div_q);

    // Parity of the incoming word; even parity is the plain XOR.
    always_comb begin
        parity_d = ^data_i;
        if (PARITY == 1) begin
            parity_d = ~parity_d;
        end
    end

    // Pop strobe: only in IDLE, and held off while reset is asserted.
    assign rd_o   = rst_n_i && (state_q == S_IDLE) && rdy_i;
    assign tx_o   = tx_q;
    assign busy_o = busy_q;

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            // Baud counter free-runs 0..D while a frame is active.
            if (state_q != S_IDLE) begin
                if (baud_done_d) begin
                    baud_cnt_q <= '0;
                end else begin
                    baud_cnt_q <= baud_cnt_q + DIV_W'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (rdy_i) begin
                        shift_q    <= data_i;
                        div_q      <= baud_div_i;
                        parity_q   <= parity_d;
                        baud_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end

                S_START: begin
                    if (baud_done_d) begin
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (baud_done_d) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            if (PARITY != 0) begin
                                tx_q    <= parity_q;
                                state_q <= S_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            // Next bit is the one about to shift into position 0.
                            tx_q      <= shift_q[1];
                        end
                    end
                end

                S_PAR: begin
                    if (baud_done_d) begin
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                        state_q   <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (baud_done_d) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ser.sv
`timescale 1ns/1ps
// Testbench for uart_tx_ser: three instances (no parity / even+2 stop / odd),
// expected line levels per clock queued at pop time and compared per cycle.
module tb_uart_tx_ser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [7:0]  data;
    logic [2:0]  rdy;
    logic [2:0]  rd;
    logic [2:0]  tx;
    logic [2:0]  busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx_ser #(.DATA_W(8), .DIV_W(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .baud_div_i(baud_div), .data_i(data),
        .rdy_i(rdy[0]), .rd_o(rd[0]), .tx_o(tx[0]), .busy_o(busy[0])
    );

    uart_tx_ser #(.DATA_W(8), .DIV_W(16), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .baud_div_i(baud_div), .data_i(data),
        .rdy_i(rdy[1]), .rd_o(rd[1]), .tx_o(tx[1]), .busy_o(busy[1])
    );

    uart_tx_ser #(.DATA_W(8), .DIV_W(16), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .baud_div_i(baud_div), .data_i(data),
        .rdy_i(rdy[2]), .rd_o(rd[2]), .tx_o(tx[2]), .busy_o(busy[2])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lvl(input logic b, input int div);
        repeat (div + 1) exp_q.push_back(b);
    endtask

    // Queue the per-clock line levels of one frame.
    task automatic push_frame(input logic [7:0] d, input int par, input int stops, input int div);
        logic p;
        p = 1'b0;
        push_lvl(1'b0, div);
        for (int i = 0; i < 8; i++) begin
            push_lvl(d[i], div);
            p = p ^ d[i];
        end
        if (par == 2) push_lvl(p, div);
        if (par == 1) push_lvl(~p, div);
        for (int i = 0; i < stops; i++) push_lvl(1'b1, div);
    endtask

    // Compare nclk cycles of an active frame against the queue.
    task automatic check_frame(input int inst, input int nclk, input string tag);
        logic e;
        for (int i = 0; i < nclk; i++) begin
            #1;
            if (exp_q.size() == 0) begin
                chk({tag, "_underflow"}, 1'b1, 1'b0);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            chk({tag, "_tx"}, tx[inst], e);
            chk({tag, "_busy"}, busy[inst], 1'b1);
            chk({tag, "_rd"}, rd[inst], 1'b0);
            tick();
        end
    endtask

    task automatic idle_chk(input int inst, input string tag);
        #1;
        chk({tag, "_idle_tx"}, tx[inst], 1'b1);
        chk({tag, "_idle_busy"}, busy[inst], 1'b0);
        chk({tag, "_idle_rd"}, rd[inst], rdy[inst]);
    endtask

    // Present a word and check the pop strobe, then take the edge.
    task automatic pop_word(input int inst, input logic [7:0] d, input int div, input string tag);
        data      = d;
        baud_div  = 16'(div);
        rdy[inst] = 1'b1;
        #1;
        chk({tag, "_pop"}, rd[inst], 1'b1);
        tick();
    endtask

    initial begin
        logic [7:0] words [3];
        words[0] = 8'h12;
        words[1] = 8'h34;
        words[2] = 8'h81;

        rst_n    = 1'b0;
        rdy      = 3'b000;
        data     = 8'h00;
        baud_div = 16'd3;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk("reset_tx", tx[k], 1'b1);
            chk("reset_busy", busy[k], 1'b0);
            chk("reset_rd", rd[k], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single 0xA5 frame, 4 clocks/bit, 40 busy clocks.
        push_frame(8'hA5, 0, 1, 3);
        pop_word(0, 8'hA5, 3, "t1");
        rdy[0] = 1'b0;
        check_frame(0, 40, "t1");
        idle_chk(0, "t1");
        tick();
        idle_chk(0, "t1b");

        // Even parity, two stop bits, one clock per bit.
        push_frame(8'h07, 2, 2, 0);
        pop_word(1, 8'h07, 0, "t2");
        rdy[1] = 1'b0;
        check_frame(1, 12, "t2");
        idle_chk(1, "t2");

        // Odd parity.
        push_frame(8'h07, 1, 1, 0);
        pop_word(2, 8'h07, 0, "t3");
        rdy[2] = 1'b0;
        check_frame(2, 11, "t3");
        idle_chk(2, "t3");

        // Three queued words, rdy held high: pops 21 clocks apart.
        for (int w = 0; w < 3; w++) begin
            push_frame(words[w], 0, 1, 1);
            pop_word(0, words[w], 1, "t4");
            if (w < 2) data = words[w + 1];
            else rdy[0] = 1'b0;
            check_frame(0, 20, "t4");
            if (w < 2) begin
                #1;
                chk("t4_gap_tx", tx[0], 1'b1);
                chk("t4_gap_busy", busy[0], 1'b0);
            end
        end
        idle_chk(0, "t4");
        tick();
        idle_chk(0, "t4b");

        // Divisor change during bit 4 applies only to the next frame.
        push_frame(8'h5A, 0, 1, 3);
        pop_word(0, 8'h5A, 3, "t5");
        rdy[0] = 1'b0;
        check_frame(0, 22, "t5a");
        baud_div = 16'd7;
        check_frame(0, 18, "t5b");
        idle_chk(0, "t5");
        push_frame(8'hE1, 0, 1, 7);
        pop_word(0, 8'hE1, 7, "t5n");
        rdy[0] = 1'b0;
        check_frame(0, 80, "t5n");
        idle_chk(0, "t5n");

        // Reset during data bit 2, then a fresh frame on the first edge.
        push_frame(8'hC3, 0, 1, 3);
        pop_word(0, 8'hC3, 3, "t6");
        rdy[0] = 1'b0;
        check_frame(0, 13, "t6");
        #2;
        rst_n  = 1'b0;
        rdy[0] = 1'b1;
        data   = 8'h96;
        #1;
        chk("t6_rst_tx", tx[0], 1'b1);
        chk("t6_rst_busy", busy[0], 1'b0);
        chk("t6_rst_rd", rd[0], 1'b0);
        exp_q.delete();
        repeat (2) begin
            tick();
            #1;
            chk("t6_inrst_rd", rd[0], 1'b0);
            chk("t6_inrst_tx", tx[0], 1'b1);
        end
        rst_n = 1'b1;
        #1;
        chk("t6_rel_pop", rd[0], 1'b1);
        push_frame(8'h96, 0, 1, 3);
        tick();
        rdy[0] = 1'b0;
        check_frame(0, 40, "t6n");
        idle_chk(0, "t6n");
        chk("t6_queue_empty", 1'(exp_q.size() == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
